// File: rtl/moore_stim_gen.sv
// Stimulus generator that steers the six-state Moore lab machine to a requested state
// along a shortest path. Defining MOORE_STIM_CHECK_EN enables the shadow/observed mismatch check.
module moore_stim_gen #(
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] target,
    input  logic [2:0] state_obs,
    output logic       in_bit,
    output logic [2:0] shadow_state,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] steps,
    output logic       mismatch
);

    typedef enum logic {
        ST_IDLE,
        ST_STEER
    } state_t;

    state_t     r_state;
    state_t     w_state_n;
    logic [2:0] r_shadow;
    logic [2:0] r_tgt;
    logic [1:0] r_steps;
    logic [2:0] w_tgt_n;
    logic [1:0] w_steps_n;
    logic       w_in_bit;
    logic       w_done;
    logic       w_err;

    function automatic logic [2:0] f_next(input logic [2:0] s, input logic b);
        logic [2:0] n;
        case (s)
            3'd0:    n = b ? 3'd2 : 3'd1;
            3'd1:    n = b ? 3'd5 : 3'd4;
            3'd2:    n = b ? 3'd3 : 3'd1;
            3'd3:    n = b ? 3'd0 : 3'd1;
            3'd4:    n = b ? 3'd5 : 3'd4;
            3'd5:    n = b ? 3'd0 : 3'd3;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Bit t of each row is the first bit of a shortest path from s to t (ties resolved to 0).
    function automatic logic f_hop(input logic [2:0] s, input logic [2:0] t);
        logic [7:0] m;
        case (s)
            3'd0:    m = 8'b0000_1100;
            3'd1:    m = 8'b0010_1101;
            3'd2:    m = 8'b0000_1001;
            3'd3:    m = 8'b0000_0101;
            3'd4:    m = 8'b0010_1111;
            3'd5:    m = 8'b0000_0101;
            default: m = 8'b0000_0000;
        endcase
        return m[t];
    endfunction

    always_comb begin
        w_state_n = r_state;
        w_tgt_n   = r_tgt;
        w_steps_n = r_steps;
        w_in_bit  = IDLE_BIT;
        w_done    = 1'b0;
        w_err     = 1'b0;
        if (rst_n) begin
            if (r_state == ST_STEER) begin
                if (r_shadow == r_tgt) begin
                    w_done    = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_in_bit  = f_hop(r_shadow, r_tgt);
                    w_steps_n = r_steps + 2'd1;
                end
            end else if (start) begin
                if (target > 3'd5) begin
                    w_err = 1'b1;
                end else if (target == r_shadow) begin
                    w_done    = 1'b1;
                    w_steps_n = 2'd0;
                end else begin
                    w_tgt_n   = target;
                    w_steps_n = 2'd1;
                    w_in_bit  = f_hop(r_shadow, target);
                    w_state_n = ST_STEER;
                end
            end
        end
    end

    // The shadow follows the driven bit every cycle, idle or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_shadow <= 3'd0;
            r_tgt    <= 3'd0;
            r_steps  <= 2'd0;
        end else begin
            r_state  <= w_state_n;
            r_shadow <= f_next(r_shadow, w_in_bit);
            r_tgt    <= w_tgt_n;
            r_steps  <= w_steps_n;
        end
    end

`ifdef MOORE_STIM_CHECK_EN
    logic r_mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mismatch <= 1'b0;
        end else if (state_obs != r_shadow) begin
            r_mismatch <= 1'b1;
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_obs;

    assign w_unused_obs = ^state_obs;
    assign mismatch     = 1'b0;
`endif

    assign in_bit       = w_in_bit;
    assign done         = w_done;
    assign err          = w_err;
    assign busy         = (r_state == ST_STEER);
    assign shadow_state = r_shadow;
    assign steps        = r_steps;

endmodule

// File: doc/moore_stim_gen.md
# moore_stim_gen

Stimulus generator for the six-state Moore machine lab block: drives that machine's serial `in` bit so the machine walks to a requested target state along a shortest path. A shadow copy of the machine's transition function tracks the machine's state every cycle, including idle cycles. It is the driving end of the machine's one-bit input interface, used by benches and FPGA top-levels in place of a manual switch.

## Interface
- `IDLE_BIT`, 1'b0, value driven on `in_bit` whenever no steering is in progress.
- `clk`  in  1  clock; all state changes on posedge.
- `rst_n`  in  1  reset, synchronous, active-low; must be the same reset as the driven machine.
- `start`  in  1  command strobe; sampled every cycle.
- `target`  in  3  requested state, valid 0..5; sampled when `start`=1.
- `state_obs`  in  3  driven machine's state output; used only with the check macro.
- `in_bit`  out  1  connects to the machine's `in`.
- `shadow_state`  out  3  modelled machine state.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse in the cycle the machine sits in the target.
- `err`  out  1  one-cycle pulse on a rejected command.
- `steps`  out  2  bits steered for the current or last command.
- `mismatch`  out  1  sticky shadow/observed disagreement.

## Operation
- Transition function (state: in=0 -> , in=1 ->):
  - S0: S1, S2
  - S1: S4, S5
  - S2: S1, S3
  - S3: S1, S0
  - S4: S4, S5
  - S5: S3, S0
- Every cycle: `shadow_state` <= f(`shadow_state`, `in_bit`). This applies whether busy or idle.
- Hop bit hop(s,t): first bit of a shortest path from s to t. If both bits give equal-length paths, choose 0. The longest shortest path is 3 steps.
- Accept condition: `start`=1 and `busy`=0.
  - `target`>5: `err`=1 this cycle; nothing latched.
  - `target`==`shadow_state`: `done`=1 this cycle; `busy` stays 0; `steps`<=0; `in_bit`=`IDLE_BIT`.
  - Otherwise: latch `tgt_q`<=`target` and `steps`<=1. `in_bit`=hop(`shadow_state`,`target`) in this same cycle. `busy`<=1.
- While `busy`=1:
  - If `shadow_state`!=`tgt_q`: `in_bit`=hop(`shadow_state`,`tgt_q`) and `steps` increments.
  - If `shadow_state`==`tgt_q`: `done`=1, `in_bit`=`IDLE_BIT`, `busy`<=0.
- `start` while `busy`=1 is ignored, with no `err`. This includes the `done` cycle.
- All other cycles: `in_bit`=`IDLE_BIT`.
- `in_bit`, `done` and `err` are combinational from registered state and `start`/`target`. `shadow_state`, `busy`, `steps`, `tgt_q` and `mismatch` are registers.

## Timing
- Reset values: `shadow_state`=0, `busy`=0, `steps`=0, `tgt_q`=0, `mismatch`=0. `in_bit`=`IDLE_BIT`, `done`=0, `err`=0 while `rst_n`=0.
- Latency: a path of N bits is accepted in cycle k, drives bits in cycles k..k+N-1, and pulses `done` in cycle k+N with `busy` low from k+N+1. N is 0..3.
- The machine leaves the target at the edge after `done` unless f(target,`IDLE_BIT`)=target. Only S4 holds with the default `IDLE_BIT`.
- Reset mid-command aborts it: no `done`, shadow returns to S0, and the next cycle is idle.

## Configuration
- `MOORE_STIM_CHECK_EN` defined: each cycle, `state_obs`!=`shadow_state` sets `mismatch`<=1. It clears only on reset.
- Not defined: `mismatch` is tied to 0 and `state_obs` is ignored. Ports are present in both builds.

## Test plan
- Reset, then `start`, `target`=3 in the first cycle -> `in_bit` 1,1; shadow 0->2->3; `done` in the third cycle; `steps`=2.
- Reset, `target`=4 -> bits 0,0; `done`; the shadow then stays S4 indefinitely with idle bit 0.
- From the S4 idle state, `target`=1 (tie at S5) -> bits 1,0,0; shadow 4->5->3->1; `steps`=3.
- Reset, `start`, `target`=0 in the first cycle -> `done` the same cycle, `busy`=0, `in_bit`=0, shadow becomes S1.
- `target`=6 -> `err` one cycle, no `busy`. A `start` during `busy` is ignored and the original target completes.
- `MOORE_STIM_CHECK_EN` build, force `state_obs`=5 while the shadow is S2 -> `mismatch`=1 next cycle and it stays 1 until reset.
